// File: rtl/counter_reader.sv
// Snapshots a wide counter on capture_i and streams it LSB-first as bytes over valid/ready.
// Define COUNTER_READER_HEADER_EN to prefix each frame with a 0xA5 header byte.
module counter_reader #(
  parameter int COUNTER_SIZE = 40
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [COUNTER_SIZE-1:0] counterIn_i,
  input  logic                    capture_i,
  input  logic                    clearOverrun_i,
  output logic [7:0]              data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  localparam int NUM_BYTES = (COUNTER_SIZE + 7) / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES + 1);
  localparam int SNAP_W    = NUM_BYTES * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

`ifdef COUNTER_READER_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, HEADER = 2'd2} state_t;
  localparam state_t FIRST = HEADER;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, DATA = 1'b1} state_t;
  localparam state_t FIRST = DATA;
`endif

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [SNAP_W-1:0] snap, snap_n;
  logic              ovr_n, xfer, end_xfer;
  logic [7:0]        byte_n, data_n;
  logic              valid_n, last_n;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    snap_n   = snap;
    ovr_n    = overrun_o;
    xfer     = valid_o & ready_i;
    end_xfer = xfer & last_o;

    if (clearOverrun_i)
      ovr_n = 1'b0;

    if (capture_i && (state == IDLE || end_xfer)) begin
      snap_n                   = '0;
      snap_n[COUNTER_SIZE-1:0] = counterIn_i;
      idx_n                    = '0;
      state_n                  = FIRST;
    end else begin
      // Reaching here with capture_i set means a frame is mid-flight: drop it.
      if (capture_i)
        ovr_n = 1'b1;
      if (xfer) begin
`ifdef COUNTER_READER_HEADER_EN
        if (state == HEADER) begin
          state_n = DATA;
          idx_n   = '0;
        end
`endif
        if (state == DATA) begin
          if (last_o) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
    end

    byte_n = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++)
      if (idx_n == IDX_W'(k))
        byte_n = snap_n[k*8 +: 8];

    data_n = 8'h00;
    if (state_n == DATA)
      data_n = byte_n;
`ifdef COUNTER_READER_HEADER_EN
    if (state_n == HEADER)
      data_n = 8'hA5;
`endif
    valid_n = (state_n != IDLE);
    last_n  = (state_n == DATA) && (idx_n == LAST_IDX);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      idx       <= '0;
      snap      <= '0;
      data_o    <= 8'h00;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      snap      <= snap_n;
      data_o    <= data_n;
      valid_o   <= valid_n;
      last_o    <= last_n;
      busy_o    <= valid_n;
      overrun_o <= ovr_n;
    end
  end

endmodule

// File: tb/tb_counter_reader.sv
// Directed bench for counter_reader: a 40-bit and a 12-bit instance, header-aware via COUNTER_READER_HEADER_EN.
module tb_counter_reader;

`ifdef COUNTER_READER_HEADER_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif
  localparam int NFA = 5 + HB;
  localparam int NFB = 2 + HB;

  logic        clk = 1'b0;
  logic        rst_a, cap_a, clr_a, ready_a;
  logic [39:0] cnt_a;
  logic [7:0]  data_a;
  logic        valid_a, last_a, busy_a, ovr_a;

  logic        rst_b, cap_b, clr_b, ready_b;
  logic [11:0] cnt_b;
  logic [7:0]  data_b;
  logic        valid_b, last_b, busy_b, ovr_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  counter_reader #(.COUNTER_SIZE(40)) dut_a (
    .clock_i(clk), .reset_i(rst_a), .counterIn_i(cnt_a), .capture_i(cap_a),
    .clearOverrun_i(clr_a), .data_o(data_a), .valid_o(valid_a), .ready_i(ready_a),
    .last_o(last_a), .busy_o(busy_a), .overrun_o(ovr_a));

  counter_reader #(.COUNTER_SIZE(12)) dut_b (
    .clock_i(clk), .reset_i(rst_b), .counterIn_i(cnt_b), .capture_i(cap_b),
    .clearOverrun_i(clr_b), .data_o(data_b), .valid_o(valid_b), .ready_i(ready_b),
    .last_o(last_b), .busy_o(busy_b), .overrun_o(ovr_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] d, input logic v, input logic l);
    chk({tag, " data"},  data_a,  d);
    chk({tag, " valid"}, valid_a, v);
    chk({tag, " last"},  last_a,  l);
    chk({tag, " busy"},  busy_a,  v);
  endtask

  task automatic chk_b(input string tag, input logic [7:0] d, input logic v, input logic l);
    chk({tag, " data"},  data_b,  d);
    chk({tag, " valid"}, valid_b, v);
    chk({tag, " last"},  last_b,  l);
    chk({tag, " busy"},  busy_b,  v);
  endtask

  function automatic logic [7:0] exp_a(input logic [39:0] v, input int p);
    if (p < HB) return 8'hA5;
    return v[(p-HB)*8 +: 8];
  endfunction

  initial begin
    logic [7:0]  hand_a [5];
    logic [7:0]  hand_b [2];
    logic [7:0]  hand_c [2];
    logic [39:0] v;
    logic [39:0] v2;
    hand_a = '{8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
    hand_b = '{8'hBC, 8'h0A};
    hand_c = '{8'h23, 8'h01};

    rst_a = 1'b1; cap_a = 1'b0; clr_a = 1'b0; ready_a = 1'b0; cnt_a = '0;
    rst_b = 1'b1; cap_b = 1'b0; clr_b = 1'b0; ready_b = 1'b0; cnt_b = '0;
    @(negedge clk);
    @(negedge clk);
    chk_a("reset_a", 8'h00, 1'b0, 1'b0);
    chk("reset_a ovr", ovr_a, 1'b0);
    chk_b("reset_b", 8'h00, 1'b0, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk_a("idle_a", 8'h00, 1'b0, 1'b0);

    // Basic frame, ready held high.
    cnt_a = 40'h12_3456_789A; cap_a = 1'b1; ready_a = 1'b1;
    @(negedge clk);
    cap_a = 1'b0; cnt_a = 40'h0;
`ifdef COUNTER_READER_HEADER_EN
    chk_a("basic hdr", 8'hA5, 1'b1, 1'b0);
    @(negedge clk);
`endif
    for (int k = 0; k < 5; k++) begin
      chk_a($sformatf("basic b%0d", k), hand_a[k], 1'b1, k == 4);
      @(negedge clk);
    end
    chk_a("basic after", 8'h00, 1'b0, 1'b0);

    // Stalls with a moving live counter.
    v = 40'hFF_0000_00FE;
    cnt_a = v; cap_a = 1'b1; ready_a = 1'b0;
    @(negedge clk);
    cap_a = 1'b0;
    for (int p = 0; p < NFA; p++) begin
      for (int s = 0; s < 3; s++) begin
        chk_a($sformatf("stall p%0d s%0d", p, s), exp_a(v, p), 1'b1, p == NFA-1);
        ready_a = (s == 2);
        cnt_a = cnt_a + 40'd1;
        @(negedge clk);
      end
    end
    chk_a("stall after", 8'h00, 1'b0, 1'b0);

    // Overrun, clear, then capture coincident with last transfer.
    v  = 40'hC3_B2A1_9080;
    v2 = 40'h0F_1E2D_3C4B;
    cnt_a = v; cap_a = 1'b1; ready_a = 1'b1;
    @(negedge clk);
    cap_a = 1'b0; cnt_a = 40'hDE_AD00_BEEF;
    for (int p = 0; p < NFA; p++) begin
      chk_a($sformatf("ovr p%0d", p), exp_a(v, p), 1'b1, p == NFA-1);
      chk($sformatf("ovr flag p%0d", p), ovr_a, p == HB+3);
      if (p == HB+2) cap_a = 1'b1;
      if (p == HB+3) clr_a = 1'b1;
      if (p == NFA-1) begin cap_a = 1'b1; cnt_a = v2; end
      @(negedge clk);
      cap_a = 1'b0; clr_a = 1'b0; cnt_a = 40'h55_5555_5555;
    end
    for (int p = 0; p < NFA; p++) begin
      chk_a($sformatf("b2b p%0d", p), exp_a(v2, p), 1'b1, p == NFA-1);
      chk($sformatf("b2b flag p%0d", p), ovr_a, p == HB+2);
      if (p == HB+1) begin cap_a = 1'b1; clr_a = 1'b1; end
      if (p == HB+2) clr_a = 1'b1;
      @(negedge clk);
      cap_a = 1'b0; clr_a = 1'b0;
    end
    chk_a("b2b after", 8'h00, 1'b0, 1'b0);
    chk("b2b after ovr", ovr_a, 1'b0);

    // 12-bit instance: padded final byte.
    cnt_b = 12'hABC; cap_b = 1'b1; ready_b = 1'b1;
    @(negedge clk);
    cap_b = 1'b0; cnt_b = 12'hFFF;
`ifdef COUNTER_READER_HEADER_EN
    chk_b("c12 hdr", 8'hA5, 1'b1, 1'b0);
    @(negedge clk);
`endif
    for (int k = 0; k < 2; k++) begin
      chk_b($sformatf("c12 b%0d", k), hand_b[k], 1'b1, k == 1);
      @(negedge clk);
    end
    chk_b("c12 after", 8'h00, 1'b0, 1'b0);

    // Reset mid-frame on the 12-bit instance.
    cnt_b = 12'h5A3; cap_b = 1'b1; ready_b = 1'b0;
    @(negedge clk);
    cap_b = 1'b0;
    chk_b("rst pre", (HB == 1) ? 8'hA5 : 8'hA3, 1'b1, 1'b0);
    #2 rst_b = 1'b1;
    #1;
    chk_b("rst async", 8'h00, 1'b0, 1'b0);
    chk("rst async ovr", ovr_b, 1'b0);
    @(negedge clk);
    rst_b = 1'b0; ready_b = 1'b1;
    @(negedge clk);
    chk_b("rst idle", 8'h00, 1'b0, 1'b0);
    cnt_b = 12'h123; cap_b = 1'b1;
    @(negedge clk);
    cap_b = 1'b0;
`ifdef COUNTER_READER_HEADER_EN
    chk_b("post rst hdr", 8'hA5, 1'b1, 1'b0);
    @(negedge clk);
`endif
    for (int k = 0; k < 2; k++) begin
      chk_b($sformatf("post rst b%0d", k), hand_c[k], 1'b1, k == 1);
      @(negedge clk);
    end
    chk_b("post rst after", 8'h00, 1'b0, 1'b0);
    chk("frame len b", NFB, 2 + HB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_reader.md
COUNTER_READER -- requirements
Module: counter_reader

Interface
REQ-001 The block SHALL have parameter COUNTER_SIZE, default 40: width of the counter value to be read out; legal range 8..64.
REQ-002 The block SHALL derive localparam NUM_BYTES = ceil(COUNTER_SIZE/8), which is 5 at the default COUNTER_SIZE.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clock_i  input  1  single clock, all logic on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 counterIn_i  input  COUNTER_SIZE  live counter value to be sampled.
REQ-006 capture_i  input  1  single-cycle request to snapshot counterIn_i and stream it out.
REQ-007 clearOverrun_i  input  1  synchronous clear of overrun_o.
REQ-008 data_o  output  8  current output byte.
REQ-009 valid_o  output  1  data_o holds a byte offered to the sink.
REQ-010 ready_i  input  1  sink accepts data_o this cycle.
REQ-011 last_o  output  1  data_o is the final byte of the current frame.
REQ-012 busy_o  output  1  a frame is in progress (state not IDLE).
REQ-013 overrun_o  output  1  sticky flag: a capture request was dropped.

Function
REQ-014 The FSM SHALL have states IDLE, HEADER (present only with the macro in REQ-031) and DATA.
REQ-015 In IDLE, capture_i=1 SHALL latch counterIn_i into the snapshot register on that edge and move to HEADER (macro defined) or DATA (macro undefined).
REQ-016 valid_o SHALL be 1 exactly while the state is HEADER or DATA, so the first byte is offered one cycle after capture_i.
REQ-017 A byte transfer SHALL occur on any rising edge where valid_o=1 and ready_i=1, with no other condition.
REQ-018 While valid_o=1 and ready_i=0, data_o, last_o and the state SHALL hold stable.
REQ-019 DATA SHALL send the snapshot LSB-first: byte k = snapshot[8k+7:8k] for k = 0..NUM_BYTES-1.
REQ-020 If COUNTER_SIZE is not a multiple of 8, the unused upper bits of the final byte SHALL be 0.
REQ-021 The byte index counter SHALL be ceil(log2(NUM_BYTES+1)) bits wide, reset to 0 on entry to DATA, and increment by 1 per DATA transfer.
REQ-022 last_o SHALL be 1 only in DATA when the byte index equals NUM_BYTES-1.
REQ-023 A transfer with last_o=1 SHALL return the FSM to IDLE, unless capture_i=1 on that same edge.
REQ-024 If capture_i=1 on the same edge as a transfer with last_o=1, the block SHALL latch the new snapshot and start a new frame with no idle cycle; this SHALL NOT set overrun_o.
REQ-025 Any other capture_i=1 while busy_o=1 SHALL be ignored (snapshot unchanged) and SHALL set overrun_o.
REQ-026 overrun_o SHALL clear when clearOverrun_i=1; if a set and a clear occur on the same edge, the set SHALL win.
REQ-027 While valid_o=0, data_o SHALL be 0x00.
REQ-028 The live counterIn_i SHALL NOT affect the output after the capture edge; only the snapshot is streamed.

Reset
REQ-029 reset_i=1 SHALL asynchronously force: state=IDLE, byte index=0, snapshot=0, data_o=0x00, valid_o=0, last_o=0, busy_o=0, overrun_o=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no further bytes offered; after reset is released, the first capture_i SHALL start a complete new frame.

Configuration
REQ-031 The block SHALL support macro COUNTER_READER_HEADER_EN: when it is defined, each frame SHALL begin with the HEADER state sending byte 0xA5 (last_o=0), followed by DATA; when it is undefined, the HEADER state and its logic SHALL be absent and frames SHALL consist of exactly NUM_BYTES bytes.

Verification
REQ-032 Verification SHALL cover: macro undefined, COUNTER_SIZE=40, counterIn_i=0x12_3456_789A, one-cycle capture_i, ready_i held 1 -> bytes 9A,78,56,34,12 on 5 consecutive cycles starting 1 cycle after capture; last_o only on 12; busy_o low on the following cycle.
REQ-033 Verification SHALL cover: macro defined, same stimulus as REQ-032 -> bytes A5,9A,78,56,34,12; 6 cycles total.
REQ-034 Verification SHALL cover: ready_i toggling 1,0,0,1,... while counterIn_i keeps incrementing -> data_o stable while stalled; all bytes match the value at the capture edge.
REQ-035 Verification SHALL cover: capture_i at byte 2 of a frame -> frame unchanged and overrun_o=1; then clearOverrun_i pulsed -> overrun_o=0 on the next cycle; capture_i coincident with the last-byte transfer -> new frame back-to-back and overrun_o stays 0.
REQ-036 Verification SHALL cover: COUNTER_SIZE=12, value 0xABC -> bytes BC, 0A; then reset_i pulsed mid-frame in a separate run -> all outputs 0 immediately, next capture_i yields a full frame.
